// File: rtl/instr_pkg.sv
// instr_pkg: instruction type codes, RV32I opcodes, NOP word and encoder FSM states
package instr_pkg;
    typedef enum logic [3:0] {
        T_R       = 4'd0,
        T_I_LW    = 4'd1,
        T_I_ADDI  = 4'd2,
        T_I_JALR  = 4'd3,
        T_S       = 4'd4,
        T_SB      = 4'd5,
        T_U_AUIPC = 4'd6,
        T_U_LUI   = 4'd7,
        T_UJ      = 4'd8
    } instr_type_e;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_LW    = 7'h03;
    localparam logic [6:0] OP_ADDI  = 7'h13;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_S     = 7'h23;
    localparam logic [6:0] OP_SB    = 7'h63;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_UJ    = 7'h6f;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field packer; IMM_RANGE_CHECK_EN enables immediate range checks
module instr_pack import instr_pkg::*; (
    input  logic [3:0]  typ,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        bad_type,
    output logic        bad_imm
);
    logic [31:0] raw;

    // place fields per format; unknown type codes fall through to NOP
    always_comb begin
        raw = NOP;
        bad_type = 1'b0;
        case (typ)
            T_R:       raw = {f7, rs2, rs1, f3, rd, OP_R};
            T_I_LW:    raw = {imm[11:0], rs1, f3, rd, OP_LW};
            T_I_ADDI:  raw = {imm[11:0], rs1, f3, rd, OP_ADDI};
            T_I_JALR:  raw = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            T_S:       raw = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
            T_SB:      raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_SB};
            T_U_AUIPC: raw = {imm[31:12], rd, OP_AUIPC};
            T_U_LUI:   raw = {imm[31:12], rd, OP_LUI};
            T_UJ:      raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_UJ};
            default:   bad_type = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic range_ok;

    // immediate must be representable in the format's field without loss
    always_comb begin
        range_ok = 1'b1;
        case (typ)
            T_I_LW, T_I_ADDI, T_I_JALR, T_S:
                range_ok = imm[31:11] == {21{imm[11]}};
            T_SB:
                range_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            T_UJ:
                range_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            T_U_AUIPC, T_U_LUI:
                range_ok = imm[11:0] == 12'd0;
            default:
                range_ok = 1'b1;
        endcase
    end

    assign bad_imm = !bad_type && !range_ok;
`else
    assign bad_imm = 1'b0;
`endif

    assign word = (bad_type || bad_imm) ? NOP : raw;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder with session FSM, output register, address and word count
module instr_encoder import instr_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  word_count,
    output logic              err_invalid,
    output logic              err_imm
);
    state_e      state, state_nx;
    logic        in_fire, out_fire, load, bad_type, bad_imm;
    logic [31:0] word;

    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign load     = (state == S_IDLE) && start;
    assign busy     = state != S_IDLE;

    instr_pack u_pack (
        .typ      (in_type),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .f3       (in_funct3),
        .f7       (in_funct7),
        .imm      (in_imm),
        .word     (word),
        .bad_type (bad_type),
        .bad_imm  (bad_imm)
    );

    // session state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;

    // session sequencing: open on start, drain after the last beat, close once it leaves
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_RUN : S_IDLE;
            S_RUN:   state_nx = (in_fire && in_last) ? S_DRAIN : S_RUN;
            S_DRAIN: state_nx = out_fire ? S_IDLE : S_DRAIN;
            default: state_nx = S_IDLE;
        endcase
    end

    // output slot, address/count tracking and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_addr    <= '0;
            word_count  <= '0;
            done        <= 1'b0;
            err_invalid <= 1'b0;
            err_imm     <= 1'b0;
        end else begin
            done <= (state == S_DRAIN) && out_fire;
            if (in_fire) begin
                out_valid <= 1'b1;
                out_instr <= word;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (load) begin
                out_addr    <= {base_addr[ADDR_W-1:2], 2'b00};
                word_count  <= '0;
                err_invalid <= 1'b0;
                err_imm     <= 1'b0;
            end else begin
                if (out_fire) begin
                    out_addr   <= out_addr + ADDR_W'(4);
                    word_count <= word_count + CNT_W'(1);
                end
                if (in_fire) begin
                    err_invalid <= err_invalid | bad_type;
                    err_imm     <= err_imm | bad_imm;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder (honours IMM_RANGE_CHECK_EN)
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        busy, done;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_type = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr, out_addr;
    logic [15:0] word_count;
    logic        err_invalid, err_imm;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_addr = '0;
    logic        toggle_rdy = 1'b0;
    logic        held = 1'b0;
    logic [63:0] held_v = '0;

    instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .word_count(word_count),
        .err_invalid(err_invalid), .err_imm(err_imm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference encoding written from the RV32I format tables
    function automatic logic [31:0] enc(input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
        logic [31:0] w;
        logic        ok;
        int          s;
        s = $signed(imm);
        ok = 1'b1;
        w = 32'h13;
        case (t)
            4'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
            4'd1, 4'd2, 4'd3: begin
                w = ((imm & 32'hfff) << 20) | (32'(rs1) << 15) | (t == 4'd3 ? 32'd0 : 32'(f3) << 12) | (32'(rd) << 7)
                    | (t == 4'd1 ? 32'h03 : t == 4'd2 ? 32'h13 : 32'h67);
                ok = s >= -2048 && s <= 2047;
            end
            4'd4: begin
                w = (((imm >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                    | ((imm & 32'h1f) << 7) | 32'h23;
                ok = s >= -2048 && s <= 2047;
            end
            4'd5: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | (32'(f3) << 12) | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
                ok = s >= -4096 && s <= 4095 && (imm & 1) == 0;
            end
            4'd6, 4'd7: begin
                w = (imm & 32'hffff_f000) | (32'(rd) << 7) | (t == 4'd6 ? 32'h17 : 32'h37);
                ok = (imm & 32'hfff) == 0;
            end
            4'd8: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 12) & 32'hff) << 12) | (32'(rd) << 7) | 32'h6f;
                ok = s >= -(1 << 20) && s < (1 << 20) && (imm & 1) == 0;
            end
            default: w = 32'h13;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        if (!ok) w = 32'h13;
`endif
        return w;
    endfunction

    // output monitor: pop and compare on each handshake, and check held words stay put
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_word", out_instr, held_v[63:32]);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", out_instr, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    check("instr", out_instr, e[63:32]);
                    check("addr", out_addr, e[31:0]);
                end
            end
            held = out_valid && !out_ready;
            held_v = {out_instr, out_addr};
        end
    end

    always @(posedge clk) if (toggle_rdy) #1 out_ready = ~out_ready;

    task automatic open_session(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1 start = 1'b0;
        exp_addr = b & ~32'h3;
        @(negedge clk);
        check("start_addr", out_addr, exp_addr);
        check("start_count", 32'(word_count), 32'd0);
        check("start_err", {30'd0, err_invalid, err_imm}, 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] t, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm, input logic last);
        int n = 0;
        in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back({enc(t, rd, rs1, rs2, f3, f7, imm), exp_addr});
        exp_addr += 4;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input logic [15:0] cnt);
        int n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done", 32'(done), 32'd1);
        check("word_count", 32'(word_count), 32'(cnt));
        check("idle_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] imm_tbl [8];
        imm_tbl = '{32'hffff_fff4, 32'd100, 32'hffff_f800, 32'd2047, 32'hffff_ff9c, 32'd4094, 32'habcd_e000, 32'h1234_5000};
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr", out_addr, 32'd0);
        check("rst_misc", {27'd0, busy, done, err_invalid, err_imm, 1'b0} | 32'(word_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        open_session(32'h100);
        send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        check("addi_model", sb_q[0][63:32], 32'h0050_0093);
        wait_done(16'd1);

        open_session(32'h203);
        send(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hffff_fffc, 1'b0);
        send(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1);
        wait_done(16'd2);

        open_session(32'h300);
        send(4'd12, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'd0, 1'b1);
        wait_done(16'd1);
        check("err_invalid_set", 32'(err_invalid), 32'd1);
        check("err_imm_clear", 32'(err_imm), 32'd0);

        open_session(32'h1000);
        toggle_rdy = 1'b1;
        for (int i = 0; i < 8; i++)
            send(4'(i), 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                 3'($urandom_range(7)), 7'($urandom_range(127)), imm_tbl[i], i == 7);
        wait_done(16'd8);
        toggle_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        open_session(32'h400);
        send(4'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1);
        wait_done(16'd1);
`ifdef IMM_RANGE_CHECK_EN
        check("err_imm", 32'(err_imm), 32'd1);
`else
        check("err_imm", 32'(err_imm), 32'd0);
`endif

        out_ready = 1'b0;
        open_session(32'h500);
        send(4'd0, 5'd7, 5'd8, 5'd9, 3'd2, 7'h20, 32'd0, 1'b1);
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'd1);
        check("drain_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(word_count), 32'd0);
        check("arst_addr", out_addr, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
